// File: rtl/pipeline_pkg.sv
// Shared types and constants for the RV32I inter-stage register bank
// (fetch/decode, decode/execute, execute/memory, memory/writeback).
package pipeline_pkg;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;

    localparam logic [1:0] RESULT_ALU = 2'b00;
    localparam logic [1:0] RESULT_MEM = 2'b01;
    localparam logic [1:0] RESULT_PC4 = 2'b10;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] PC;
        logic [XLEN-1:0] PCPlus4;
    } fd_t;

    typedef struct packed {
        logic               regWrite;
        logic [1:0]         resultSrc;
        logic               memWrite;
        logic               jump;
        logic [2:0]         branch;
        logic [3:0]         ALUctrl;
        logic               ALUsrc;
        logic [RADDR_W-1:0] Rs1;
        logic [RADDR_W-1:0] Rs2;
        logic [RADDR_W-1:0] Rd;
        logic [XLEN-1:0]    RD1;
        logic [XLEN-1:0]    RD2;
        logic [XLEN-1:0]    ImmExt;
        logic [XLEN-1:0]    PC;
        logic [XLEN-1:0]    PCPlus4;
    } de_t;

    typedef struct packed {
        logic               regWrite;
        logic [1:0]         resultSrc;
        logic               memWrite;
        logic [RADDR_W-1:0] Rd;
        logic [XLEN-1:0]    ALUResult;
        logic [XLEN-1:0]    writeData;
        logic [XLEN-1:0]    PCPlus4;
    } em_t;

    typedef struct packed {
        logic               regWrite;
        logic [1:0]         resultSrc;
        logic [RADDR_W-1:0] Rd;
        logic [XLEN-1:0]    ALUResult;
        logic [XLEN-1:0]    readData;
        logic [XLEN-1:0]    PCPlus4;
    } mw_t;

    localparam fd_t BUBBLE_FD = fd_t'({$bits(fd_t){1'b0}});
    localparam de_t BUBBLE_DE = de_t'({$bits(de_t){1'b0}});
    localparam em_t BUBBLE_EM = em_t'({$bits(em_t){1'b0}});
    localparam mw_t BUBBLE_MW = mw_t'({$bits(mw_t){1'b0}});

    // A stage produces the value read through rs; x0 is never a real producer.
    function automatic logic writes_reg(input logic wr, input logic [RADDR_W-1:0] rd,
                                        input logic [RADDR_W-1:0] rs);
        return wr && (rd != {RADDR_W{1'b0}}) && (rd == rs);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic em_wr, input logic [RADDR_W-1:0] em_rd,
                                           input logic mw_wr, input logic [RADDR_W-1:0] mw_rd,
                                           input logic [RADDR_W-1:0] rs);
        logic [1:0] sel;
        if (writes_reg(em_wr, em_rd, rs)) begin
            sel = FWD_MEM;
        end else if (writes_reg(mw_wr, mw_rd, rs)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_REG;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipeline_regs_if.sv
// Port group carrying the four stage bundles, hazard controls and event counters.
interface pipeline_regs_if #(
    parameter int CNT_W = 32
) ();
    import pipeline_pkg::*;

    fd_t              fd_in;
    fd_t              fd_out;
    de_t              de_in;
    de_t              de_out;
    em_t              em_in;
    em_t              em_out;
    mw_t              mw_in;
    mw_t              mw_out;
    logic             PCsrc_E;
    logic             stall_F;
    logic [1:0]       forwardA_E;
    logic [1:0]       forwardB_E;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output fd_in, de_in, em_in, mw_in, PCsrc_E,
        input  fd_out, de_out, em_out, mw_out, stall_F, forwardA_E, forwardB_E,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  fd_in, de_in, em_in, mw_in, PCsrc_E,
        output fd_out, de_out, em_out, mw_out, stall_F, forwardA_E, forwardB_E,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_unit.sv
// Stall/flush/forward decisions and saturating event counters.
// FORWARDING_EN selects load-use + forwarding; otherwise RAW dependencies stall.
module hazard_unit
    import pipeline_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] fd_rs1,
    input  logic [REG_ADDR_W-1:0] fd_rs2,
    input  logic [REG_ADDR_W-1:0] de_rs1,
    input  logic [REG_ADDR_W-1:0] de_rs2,
    input  logic [REG_ADDR_W-1:0] de_rd,
    input  logic [1:0]            de_result_src,
    input  logic                  de_reg_write,
    input  logic                  em_reg_write,
    input  logic [REG_ADDR_W-1:0] em_rd,
    input  logic                  mw_reg_write,
    input  logic [REG_ADDR_W-1:0] mw_rd,
    input  logic                  pcsrc,
    output logic                  stall_f,
    output logic                  flush_fd,
    output logic                  bubble_de,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

`ifdef FORWARDING_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             load_use_s;
    logic             raw_dep_s;
    logic             hazard_s;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    assign load_use_s = (de_result_src == RESULT_MEM) &&
                        (writes_reg(1'b1, de_rd, fd_rs1) || writes_reg(1'b1, de_rd, fd_rs2));

    // Without forwarding any in-flight producer still ahead of writeback must drain.
    assign raw_dep_s = writes_reg(de_reg_write, de_rd, fd_rs1) ||
                       writes_reg(de_reg_write, de_rd, fd_rs2) ||
                       writes_reg(em_reg_write, em_rd, fd_rs1) ||
                       writes_reg(em_reg_write, em_rd, fd_rs2);

    // Select hazard rule and operand forwarding for the configured build
    always_comb begin
        hazard_s  = 1'b0;
        forward_a = FWD_REG;
        forward_b = FWD_REG;
        if (FWD_EN) begin
            hazard_s  = load_use_s;
            forward_a = fwd_sel(em_reg_write, em_rd, mw_reg_write, mw_rd, de_rs1);
            forward_b = fwd_sel(em_reg_write, em_rd, mw_reg_write, mw_rd, de_rs2);
        end else begin
            hazard_s  = raw_dep_s;
        end
    end

    // A taken branch squashes the wrong path, so it wins over a stall.
    assign stall_f   = hazard_s && !pcsrc;
    assign flush_fd  = pcsrc;
    assign bubble_de = hazard_s || pcsrc;

    // Saturating stall and flush event counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (stall_f && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end
            if (pcsrc && (flush_cnt_r != CNT_MAX)) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE;
            end
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;

endmodule

// File: rtl/pipeline_regs.sv
// Inter-stage register bank for the five-stage RV32I core with hazard control.
// Build option: FORWARDING_EN (see hazard_unit).
module pipeline_regs
    import pipeline_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic          clk,
    input  logic          rst,
    pipeline_regs_if.slave bus
);

    logic [3*WIDTH-1:0] fd_r;
    fd_t                fd_s;
    de_t                de_r;
    em_t                em_r;
    mw_t                mw_r;
    logic               stall_f_s;
    logic               flush_fd_s;
    logic               bubble_de_s;
    logic [CNT_W-1:0]   stall_cnt_s;
    logic [CNT_W-1:0]   flush_cnt_s;

    assign fd_s = fd_t'(fd_r);

    hazard_unit #(
        .REG_ADDR_W (REG_ADDR_W),
        .CNT_W      (CNT_W)
    ) u_hazard (
        .clk           (clk),
        .rst           (rst),
        .fd_rs1        (fd_s.instr[15 +: REG_ADDR_W]),
        .fd_rs2        (fd_s.instr[20 +: REG_ADDR_W]),
        .de_rs1        (de_r.Rs1),
        .de_rs2        (de_r.Rs2),
        .de_rd         (de_r.Rd),
        .de_result_src (de_r.resultSrc),
        .de_reg_write  (de_r.regWrite),
        .em_reg_write  (em_r.regWrite),
        .em_rd         (em_r.Rd),
        .mw_reg_write  (mw_r.regWrite),
        .mw_rd         (mw_r.Rd),
        .pcsrc         (bus.PCsrc_E),
        .stall_f       (stall_f_s),
        .flush_fd      (flush_fd_s),
        .bubble_de     (bubble_de_s),
        .forward_a     (bus.forwardA_E),
        .forward_b     (bus.forwardB_E),
        .stall_cnt     (stall_cnt_s),
        .flush_cnt     (flush_cnt_s)
    );

    // F/D: squashed on a taken branch, frozen while the hazard stall is active
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fd_r <= {(3*WIDTH){1'b0}};
        end else if (flush_fd_s) begin
            fd_r <= {(3*WIDTH){1'b0}};
        end else if (!stall_f_s) begin
            fd_r <= bus.fd_in;
        end
    end

    // D/E: a bubble replaces the instruction on a stall or flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de_r <= BUBBLE_DE;
        end else if (bubble_de_s) begin
            de_r <= BUBBLE_DE;
        end else begin
            de_r <= bus.de_in;
        end
    end

    // E/M and M/W always advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            em_r <= BUBBLE_EM;
            mw_r <= BUBBLE_MW;
        end else begin
            em_r <= bus.em_in;
            mw_r <= bus.mw_in;
        end
    end

    assign bus.fd_out    = fd_s;
    assign bus.de_out    = de_r;
    assign bus.em_out    = em_r;
    assign bus.mw_out    = mw_r;
    assign bus.stall_F   = stall_f_s;
    assign bus.stall_cnt = stall_cnt_s;
    assign bus.flush_cnt = flush_cnt_s;

endmodule
